// File: rtl/regs_pkg.sv
// Shared widths and types for the 32 x 32-bit CPU register file.
package regs_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

   localparam addr_t ZERO_REG = '0;

endpackage

// File: rtl/regs_read_port.sv
// One combinational read port: address mux with zero-register and reset forcing.
// Optional write-to-read forwarding when REGS_BYPASS_EN is defined.
module regs_read_port
   import regs_pkg::*;
(
   input  logic  reset,
   input  addr_t r_addr,
   input  data_t regs [NUM_REGS],
`ifdef REGS_BYPASS_EN
   input  logic  wr_en,
   input  addr_t wr_addr,
   input  data_t wr_data,
`endif
   output data_t r_data
);

   always_comb begin
      r_data = regs[r_addr];
`ifdef REGS_BYPASS_EN
      // Forward the value being written this cycle so the reader sees it before the edge.
      if (wr_en && (wr_addr != ZERO_REG) && (wr_addr == r_addr)) begin
         r_data = wr_data;
      end
`endif
      if (reset || (r_addr == ZERO_REG)) begin
         r_data = '0;
      end
   end

endmodule

// File: rtl/regs_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Define REGS_BYPASS_EN to forward write data to a matching read port in the same cycle.
module regs_file
   import regs_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] R_Addr_A,
   input  logic [ADDR_W-1:0] R_Addr_B,
   input  logic [ADDR_W-1:0] W_Addr,
   input  logic [DATA_W-1:0] W_Data,
   input  logic              Write_reg,
   output logic [DATA_W-1:0] R_Data_A,
   output logic [DATA_W-1:0] R_Data_B
);

   data_t regs_reg [NUM_REGS];
   addr_t rd_addr  [2];
   data_t rd_data  [2];

   // Entry 0 is cleared by reset and never written, so it stays constant zero.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (Write_reg && (W_Addr != ZERO_REG)) begin
         regs_reg[W_Addr] <= W_Data;
      end
   end

   assign rd_addr[0] = R_Addr_A;
   assign rd_addr[1] = R_Addr_B;
   assign R_Data_A   = rd_data[0];
   assign R_Data_B   = rd_data[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         regs_read_port u_port (
            .reset   (Reset),
            .r_addr  (rd_addr[gi]),
            .regs    (regs_reg),
`ifdef REGS_BYPASS_EN
            .wr_en   (Write_reg),
            .wr_addr (W_Addr),
            .wr_data (W_Data),
`endif
            .r_data  (rd_data[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_regs_file.sv
// Directed bench for regs_file: table of per-cycle vectors plus reset sequences.
module tb_regs_file;
   import regs_pkg::*;

`ifdef REGS_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic  clk;
   logic  rst;
   addr_t ra, rb, wa;
   data_t wd;
   logic  we;
   data_t da, db;

   int n_vec;
   int n_err;

   regs_file dut (
      .Clk       (clk),
      .Reset     (rst),
      .R_Addr_A  (ra),
      .R_Addr_B  (rb),
      .W_Addr    (wa),
      .W_Data    (wd),
      .Write_reg (we),
      .R_Data_A  (da),
      .R_Data_B  (db)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row = one clock cycle; expectations are sampled before that cycle's rising edge.
   typedef struct {
      logic  wr;
      addr_t wa;
      data_t wd;
      addr_t ra;
      addr_t rb;
      data_t ea;
      data_t eb;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input data_t act, input data_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      tbl[0]  = '{1'b1, 5'd1,  32'h1111_1111, 5'd0,  5'd0,  32'h0, 32'h0};
      tbl[1]  = '{1'b1, 5'd2,  32'h2222_2222, 5'd1,  5'd0,  32'h1111_1111, 32'h0};
      tbl[2]  = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd2,  32'h1111_1111, 32'h2222_2222};
      tbl[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd1,  32'h0, 32'h1111_1111};
      tbl[4]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd2,  32'h0, 32'h2222_2222};
      tbl[5]  = '{1'b0, 5'd3,  32'hDEAD_BEEF, 5'd3,  5'd3,  32'h0, 32'h0};
      tbl[6]  = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h0, 32'h0};
      tbl[7]  = '{1'b1, 5'd5,  32'hA5A5_A5A5, 5'd5,  5'd1,
                  BYPASS ? 32'hA5A5_A5A5 : 32'h0, 32'h1111_1111};
      tbl[8]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
      tbl[9]  = '{1'b1, 5'd31, 32'h8000_0001, 5'd2,  5'd31,
                  32'h2222_2222, BYPASS ? 32'h8000_0001 : 32'h0};
      tbl[10] = '{1'b1, 5'd1,  32'hCAFE_F00D, 5'd31, 5'd1,
                  32'h8000_0001, BYPASS ? 32'hCAFE_F00D : 32'h1111_1111};
      tbl[11] = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd31, 32'hCAFE_F00D, 32'h8000_0001};
      tbl[12] = '{1'b1, 5'd16, 32'h0123_4567, 5'd16, 5'd15,
                  BYPASS ? 32'h0123_4567 : 32'h0, 32'h0};
      tbl[13] = '{1'b0, 5'd0,  32'h0,         5'd16, 5'd16, 32'h0123_4567, 32'h0123_4567};
      tbl[14] = '{1'b0, 5'd0,  32'h0,         5'd15, 5'd8,  32'h0, 32'h0};

      // Reset held with all inputs zero: every address reads zero on both ports.
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
      #2;
      for (int a = 0; a < NUM_REGS; a++) begin
         ra = addr_t'(a);
         rb = addr_t'(NUM_REGS - 1 - a);
         #1;
         check("reset_read_a", da, 32'h0);
         check("reset_read_b", db, 32'h0);
      end
      $display("reset sweep: %0d addresses checked on both ports", NUM_REGS);

      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         we = tbl[i].wr; wa = tbl[i].wa; wd = tbl[i].wd;
         ra = tbl[i].ra; rb = tbl[i].rb;
         #1;
         $display("vec %0d: we=%0b wa=%0d wd=%08h ra=%0d rb=%0d -> a=%08h b=%08h",
                  i, we, wa, wd, ra, rb, da, db);
         check($sformatf("vec%0d_a", i), da, tbl[i].ea);
         check($sformatf("vec%0d_b", i), db, tbl[i].eb);
      end

      // Asynchronous reset mid-cycle clears outputs before the next edge.
      @(negedge clk);
      we = 1'b0; ra = 5'd1; rb = 5'd2;
      #1;
      check("pre_async_a", da, 32'hCAFE_F00D);
      check("pre_async_b", db, 32'h2222_2222);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_a", da, 32'h0);
      check("async_rst_b", db, 32'h0);
      $display("async reset asserted mid-cycle: a=%08h b=%08h", da, db);

      // Reset dominates a write and any forwarding across a clock edge.
      we = 1'b1; wa = 5'd1; wd = 32'hFFFF_0000; ra = 5'd1; rb = 5'd1;
      #1;
      check("rst_fwd_a", da, 32'h0);
      @(posedge clk);
      #1;
      check("rst_write_a", da, 32'h0);
      check("rst_write_b", db, 32'h0);

      @(negedge clk);
      rst = 1'b0; we = 1'b0; ra = 5'd1; rb = 5'd2;
      #1;
      check("post_rst_r1", da, 32'h0);
      check("post_rst_r2", db, 32'h0);
      ra = 5'd16; rb = 5'd31;
      #1;
      check("post_rst_r16", da, 32'h0);
      check("post_rst_r31", db, 32'h0);
      $display("reset released: r16=%08h r31=%08h", da, db);

      // Same-address read/write across the committing edge on port B.
      @(negedge clk);
      we = 1'b1; wa = 5'd6; wd = 32'h5A5A_0F0F; ra = 5'd0; rb = 5'd6;
      #1;
      check("rw_pre_edge_b", db, BYPASS ? 32'h5A5A_0F0F : 32'h0);
      @(posedge clk);
      #1;
      check("rw_post_edge_b", db, 32'h5A5A_0F0F);
      check("rw_post_edge_a0", da, 32'h0);
      @(negedge clk);
      we = 1'b0;
      $display("same-address write: r6=%08h", db);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
